bin_window_3x3: RTL and testbench

//  Builds a 3x3 binary neighbourhood from a raster 1-bit pixel stream, using two 1-bit line buffers.

---
 rtl/bin_window_3x3.sv | 164 ++++++++++++++++
 tb/tb_bin_window_3x3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bin_window_3x3.sv
// 3x3 binary neighbourhood builder for the morphology stages.
// Two 1-bit line buffers, 2-clk pipeline, edge padding.
`timescale 1ns/1ps
module bin_window_3x3 #(
  parameter int   IMG_W   = 1024,
  parameter int   ADDR_W  = 10,
  parameter logic PAD_VAL = 1'b0,
  parameter logic VS_POL  = 1'b1
) (
  input  logic video_clk,
  input  logic rst_n,
  input  logic in_vs,
  input  logic in_hs,
  input  logic in_de,
  input  logic in_bin,
  output logic out_vs,
  output logic out_hs,
  output logic out_de,
  output logic bin_data_11,
  output logic bin_data_12,
  output logic bin_data_13,
  output logic bin_data_21,
  output logic bin_data_22,
  output logic bin_data_23,
  output logic bin_data_31,
  output logic bin_data_32,
  output logic bin_data_33
);

  logic              lb0_q [IMG_W];
  logic              lb1_q [IMG_W];

  logic [ADDR_W-1:0] col_q, col_d;
  logic              sat_q, sat_d;
  logic [1:0]        row_q, row_d;

  logic              de1_q, hs1_q, vs1_q;
  logic              ld1_q, pix1_q;
  logic              r0_q, r1_q;
  logic [ADDR_W-1:0] col1_q;
  logic [1:0]        row1_q;

  logic              de2_q, hs2_q, vs2_q;
  logic [8:0]        w_q, t_q;

  logic              vs_rise, de_fall;
  logic              wr, col_max;
  logic [1:0]        row_eff;
  logic [8:0]        nw, pm, t_d;
  logic              m_r1, m_r2, m_c1, m_c2;

  assign vs_rise = (in_vs == VS_POL) &&
                   (vs1_q != VS_POL);
  assign de_fall = !in_de && de1_q;
  assign wr      = in_de && !sat_q;
  assign col_max = col_q == ADDR_W'(IMG_W - 1);
  assign row_eff = vs_rise ? 2'd0 : row_q;

  always_comb begin
    col_d = col_q;
    sat_d = sat_q;
    if (!in_de) begin
      col_d = '0;
      sat_d = 1'b0;
    end else if (wr) begin
      if (col_max) sat_d = 1'b1;
      else         col_d = col_q + 1'b1;
    end
  end

  // vs clear wins over a simultaneous de falling edge
  always_comb begin
    row_d = row_q;
    if (vs_rise)
      row_d = 2'd0;
    else if (de_fall && row_q != 2'd2)
      row_d = row_q + 2'd1;
  end

  always_ff @(posedge video_clk) begin
    if (wr) begin
      lb0_q[col_q] <= in_bin;
      lb1_q[col_q] <= lb0_q[col_q];
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      sat_q  <= 1'b0;
      row_q  <= 2'd0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      ld1_q  <= 1'b0;
      pix1_q <= 1'b0;
      r0_q   <= 1'b0;
      r1_q   <= 1'b0;
      col1_q <= '0;
      row1_q <= 2'd0;
    end else begin
      col_q  <= col_d;
      sat_q  <= sat_d;
      row_q  <= row_d;
      de1_q  <= in_de;
      hs1_q  <= in_hs;
      vs1_q  <= in_vs;
      ld1_q  <= wr;
      if (wr) begin
        pix1_q <= in_bin;
        r0_q   <= lb0_q[col_q];
        r1_q   <= lb1_q[col_q];
        col1_q <= col_q;
        row1_q <= row_eff;
      end
    end
  end

  // w_q order: 11,12,13,21,22,23,31,32,33 (msb first)
  assign nw = {w_q[7], w_q[6], r1_q,
               w_q[4], w_q[3], r0_q,
               w_q[1], w_q[0], pix1_q};

  assign m_r1 = row1_q < 2'd2;
  assign m_r2 = row1_q == 2'd0;
  assign m_c1 = col1_q < ADDR_W'(2);
  assign m_c2 = col1_q == '0;

  assign pm = {m_r1 | m_c1, m_r1 | m_c2, m_r1,
               m_r2 | m_c1, m_r2 | m_c2, m_r2,
               m_c1,        m_c2,        1'b0};

  always_comb begin
    t_d = nw;
    for (int i = 0; i < 9; i++)
      if (pm[i]) t_d[i] = PAD_VAL;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      w_q   <= '0;
      t_q   <= '0;
    end else begin
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      if (ld1_q) begin
        w_q <= nw;
        t_q <= t_d;
      end
    end
  end

  assign out_de = de2_q;
  assign out_hs = hs2_q;
  assign out_vs = vs2_q;
  assign {bin_data_11, bin_data_12, bin_data_13,
          bin_data_21, bin_data_22, bin_data_23,
          bin_data_31, bin_data_32, bin_data_33} = t_q;

endmodule

// File: tb/tb_bin_window_3x3.sv
// Scoreboard bench for bin_window_3x3.
// Spatial image model predicts taps; monitor compares on out_de.
`timescale 1ns/1ps
module tb_bin_window_3x3;

  localparam int   IMG_W = 16;
  localparam logic PAD   = 1'b0;

  logic video_clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_vs = 1'b0, in_hs = 1'b0;
  logic in_de = 1'b0, in_bin = 1'b0;
  logic out_vs, out_hs, out_de;
  logic d11, d12, d13, d21, d22, d23;
  logic d31, d32, d33;

  always #5 video_clk = ~video_clk;

  bin_window_3x3 #(
    .IMG_W(IMG_W), .ADDR_W(4),
    .PAD_VAL(PAD), .VS_POL(1'b1)
  ) dut (
    .video_clk(video_clk), .rst_n(rst_n),
    .in_vs(in_vs), .in_hs(in_hs),
    .in_de(in_de), .in_bin(in_bin),
    .out_vs(out_vs), .out_hs(out_hs),
    .out_de(out_de),
    .bin_data_11(d11), .bin_data_12(d12),
    .bin_data_13(d13), .bin_data_21(d21),
    .bin_data_22(d22), .bin_data_23(d23),
    .bin_data_31(d31), .bin_data_32(d32),
    .bin_data_33(d33)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [2:0] tq[$];
  logic [8:0] xq[$];

  bit img [0:15][0:15];
  int m_row = 0, m_col = 0;
  bit m_pde = 0, m_pvs = 0;

  task automatic chk(string nm, logic [11:0] act,
                     logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] taps();
    logic [8:0] e;
    int cc, rr, c2;
    cc = (m_col < IMG_W) ? m_col : IMG_W - 1;
    for (int k = 0; k < 9; k++) begin
      rr = m_row - (2 - k / 3);
      c2 = cc - (2 - k % 3);
      e[8-k] = (rr < 0 || c2 < 0) ? PAD : img[rr][c2];
    end
    return e;
  endfunction

  task automatic step(bit vs, bit hs, bit de, bit b);
    @(negedge video_clk);
    in_vs = vs; in_hs = hs;
    in_de = de; in_bin = b;
    tq.push_back({vs, hs, de});
    if (vs && !m_pvs)       m_row = 0;
    else if (!de && m_pde)  m_row++;
    if (!de) m_col = 0;
    else begin
      if (m_col < IMG_W) img[m_row][m_col] = b;
      xq.push_back(taps());
      m_col++;
    end
    m_pde = de;
    m_pvs = vs;
  endtask

  // async reset while a line is active
  task automatic mid_reset();
    @(negedge video_clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {out_vs, out_hs, out_de,
        d11, d12, d13, d21, d22, d23,
        d31, d32, d33}, 12'h000);
    tq.delete();
    xq.delete();
    m_row = 0; m_col = 0;
    m_pde = 0; m_pvs = 0;
    repeat (3) @(negedge video_clk);
    rst_n = 1'b1;
    in_de = 1'b0; in_bin = 1'b0;
    in_vs = 1'b0; in_hs = 1'b0;
  endtask

  task automatic line(int w, int pat, bit vs_head,
                      int rst_col);
    bit b;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int c = 0; c < w; c++) begin
      if (c == rst_col) begin
        mid_reset();
        return;
      end
      if (pat == 0)      b = 1'b1;
      else if (pat == 1) b = 1'((m_row ^ c) & 1);
      else               b = 1'($urandom_range(1, 0));
      step(vs_head && c < 3, 0, 1, b);
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic vs_pulse();
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
  endtask

  task automatic frame(int w, int h, int pat);
    vs_pulse();
    for (int r = 0; r < h; r++) line(w, pat, 0, -1);
  endtask

  initial begin : monitor
    logic [2:0] e;
    logic [8:0] x;
    forever begin
      @(posedge video_clk);
      #1;
      if (rst_n && tq.size() >= 2) begin
        e = tq.pop_front();
        chk("sync_delay", {9'd0, out_vs, out_hs, out_de},
            {9'd0, e});
        if (out_de) begin
          if (xq.size() == 0)
            chk("tap_underflow", 12'd0, 12'd1);
          else begin
            x = xq.pop_front();
            chk("window", {3'd0, d11, d12, d13, d21, d22,
                d23, d31, d32, d33}, {3'd0, x});
          end
        end
      end
    end
  end

  initial begin
    #23;
    chk("reset_init", {out_vs, out_hs, out_de,
        d11, d12, d13, d21, d22, d23,
        d31, d32, d33}, 12'h000);
    @(negedge video_clk);
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0);

    frame(8, 4, 0);
    frame(16, 8, 1);

    vs_pulse();
    line(20, 2, 0, -1);
    line(16, 2, 0, -1);
    line(20, 2, 0, -1);
    line(12, 2, 0, -1);

    repeat (3) step(0, 0, 0, 0);
    line(10, 2, 1, -1);
    line(10, 2, 0, -1);
    line(10, 2, 0, -1);

    vs_pulse();
    line(12, 1, 0, -1);
    line(12, 0, 0, 6);
    line(12, 0, 0, -1);
    line(12, 2, 0, -1);
    line(12, 0, 0, -1);

    repeat (10) step(0, 0, 0, 0);
    chk("leftover", 12'(xq.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
